dmem_responder: RTL and testbench

- Memory-side responder for the load/store unit's data-memory interface.
- Accepts one read or write request per handshake and serves it from an internal byte-maskable 64-bit word array.
- Returns the full aligned 64-bit word after a programmable latency; the load/store unit does lane selection and extension.
- Sits behind the memory crossbar and models a slow on-chip data RAM for multi-cycle CPU bring-up.

---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_responder_sram_bank.sv | 41 ++++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared widths, FSM encoding and request payload layout for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned WMASK_W = 8;
    localparam int unsigned CNT_W   = 4;

    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic               wen;
        logic               ren;
        logic [DATA_W-1:0]  wdata;
        logic [WMASK_W-1:0] wmask;
    } req_payload_t;

endpackage

// File: rtl/dmem_responder_sram_bank.sv
// Single-port word array with byte enables; registered read sees the word as it was before a same-edge write.
module dmem_responder_sram_bank
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_W,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  rd_en,
    input  logic [WMASK_W-1:0]    wr_mask,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Array contents survive reset; a write is suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (en && rst_n) begin
            for (int unsigned i = 0; i < WMASK_W; i++) begin
                if (wr_mask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register only moves on an access, so it holds the response stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= rd_en ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits LATENCY cycles, commits to the bank, holds the response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DATA_W,
    parameter int unsigned           ADDR_WIDTH  = 64,
    parameter int unsigned           DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
    parameter int unsigned           LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic                  req_ren,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WMASK_W-1:0]    req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned           IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] END_ADDR = BASE_ADDR + ADDR_WIDTH'(8 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    req_payload_t          pay_q, pay_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rsp_err_d;

    req_payload_t          req_pay_c, eff_pay_c;
    logic [ADDR_WIDTH-1:0] eff_addr_c, offset_c;
    logic                  in_range_c, err_c, rd_en_c, commit_c;
    logic [WMASK_W-1:0]    wr_mask_c;
    logic [IDX_W-1:0]      idx_c;

    // With LATENCY==1 the commit edge is the accept edge, so decode the live request in IDLE.
    always_comb begin
        req_pay_c  = '{wen: req_wen, ren: req_ren, wdata: req_wdata, wmask: req_wmask};
        eff_pay_c  = (state_q == ST_IDLE) ? req_pay_c : pay_q;
        eff_addr_c = (state_q == ST_IDLE) ? req_addr  : addr_q;
        offset_c   = eff_addr_c - BASE_ADDR;
        in_range_c = (eff_addr_c >= BASE_ADDR) && (eff_addr_c < END_ADDR);
        err_c      = (eff_pay_c.wen && eff_pay_c.ren)
                   || ((eff_pay_c.wen || eff_pay_c.ren) && !in_range_c);
        rd_en_c    = eff_pay_c.ren && !err_c;
        wr_mask_c  = (eff_pay_c.wen && !err_c) ? eff_pay_c.wmask : '0;
        idx_c      = IDX_W'(offset_c >> 3);
    end

    // Next-state logic; commit_c marks the edge that enters RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pay_d     = pay_q;
        addr_d    = addr_q;
        rsp_err_d = rsp_err;
        commit_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    pay_d  = req_pay_c;
                    addr_d = req_addr;
                    if (LATENCY == 1) begin
                        state_d  = ST_RESP;
                        commit_c = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit_c) begin
            rsp_err_d = err_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pay_q     <= '0;
            addr_q    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pay_q     <= pay_d;
            addr_q    <= addr_d;
            req_ready <= (state_d == ST_IDLE);
            rsp_valid <= (state_d == ST_RESP);
            rsp_err   <= rsp_err_d;
        end
    end

    dmem_responder_sram_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (commit_c),
        .rd_en   (rd_en_c),
        .wr_mask (wr_mask_c),
        .addr    (idx_c),
        .wdata   (eff_pay_c.wdata),
        .rdata   (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2 (main), 1 and 15 (sweeps against a word model).
module tb_dmem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid, req_ready, rsp_valid, rsp_err;
    logic        rsp_ready;
    logic        req_wen, req_ren;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic [63:0] rsp_rdata [3];

    int checks = 0;
    int errors = 0;

    dmem_responder #(.LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_wen(req_wen), .req_ren(req_ren), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_wen(req_wen), .req_ren(req_ren), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_wen(req_wen), .req_ren(req_ren), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    // Issue one request on instance k from a negedge; returns at the first negedge with rsp_valid high.
    task automatic xact(input int k, input logic wen, input logic ren, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        output logic [63:0] rd, output logic er, output int gap);
        int n;
        req_wen = wen; req_ren = ren; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        req_valid[k] = 1'b1;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL accept_timeout k=%0d: req_ready got %b want 1", k, req_ready[k]); end
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        gap = 1;
        while (rsp_valid[k] !== 1'b1 && gap < 40) begin @(negedge clk); gap++; end
        checks++;
        if (rsp_valid[k] !== 1'b1) begin errors++; $display("FAIL rsp_timeout k=%0d: rsp_valid got %b want 1", k, rsp_valid[k]); end
        rd = rsp_rdata[k];
        er = rsp_err[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++; if (req_ready[k] !== 1'b1)  begin errors++; $display("FAIL reset_ready k=%0d: got %b want 1", k, req_ready[k]); end
            checks++; if (rsp_valid[k] !== 1'b0)  begin errors++; $display("FAIL reset_valid k=%0d: got %b want 0", k, rsp_valid[k]); end
            checks++; if (rsp_rdata[k] !== 64'h0) begin errors++; $display("FAIL reset_rdata k=%0d: got %h want 0", k, rsp_rdata[k]); end
            checks++; if (rsp_err[k] !== 1'b0)    begin errors++; $display("FAIL reset_err k=%0d: got %b want 0", k, rsp_err[k]); end
        end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic er; int gap;
        xact(0, 1'b1, 1'b0, BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, rd, er, gap);
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rd); end
        checks++; if (er !== 1'b0)  begin errors++; $display("FAIL wr_err: got %b want 0", er); end
        checks++; if (gap !== 2)    begin errors++; $display("FAIL wr_gap: got %0d want 2", gap); end
        xact(0, 1'b0, 1'b1, BASE + 64'h10, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL rd_rdata: got %h want 1122334455667788", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
        checks++; if (gap !== 2)   begin errors++; $display("FAIL rd_gap: got %0d want 2", gap); end
    endtask

    task automatic test_byte_write();
        logic [63:0] rd; logic er; int gap;
        xact(0, 1'b1, 1'b0, BASE, 64'h0, 8'hFF, rd, er, gap);
        xact(0, 1'b1, 1'b0, BASE, 64'h0000_0000_AB00_0000, 8'b0000_1000, rd, er, gap);
        xact(0, 1'b0, 1'b1, BASE, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'h0000_0000_AB00_0000) begin errors++; $display("FAIL sb_rdata: got %h want 00000000ab000000", rd); end
        xact(0, 1'b1, 1'b0, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, gap);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL mask0_err: got %b want 0", er); end
        xact(0, 1'b0, 1'b1, BASE, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'h0000_0000_AB00_0000) begin errors++; $display("FAIL mask0_rdata: got %h want 00000000ab000000", rd); end
        xact(0, 1'b1, 1'b0, BASE + 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, gap);
        xact(0, 1'b1, 1'b0, BASE + 64'h18, 64'h1100_0000_0000_0022, 8'h81, rd, er, gap);
        xact(0, 1'b0, 1'b1, BASE + 64'h18, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'h11FF_FFFF_FFFF_FF22) begin errors++; $display("FAIL merge_rdata: got %h want 11ffffffffffff22", rd); end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic er; int gap;
        xact(0, 1'b0, 1'b1, 64'h7FFF_FFF8, 64'h0, 8'h00, rd, er, gap);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL below_err: got %b want 1", er); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL below_rdata: got %h want 0", rd); end
        xact(0, 1'b0, 1'b1, 64'h8000_8000, 64'h0, 8'h00, rd, er, gap);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL above_err: got %b want 1", er); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL above_rdata: got %h want 0", rd); end
        xact(0, 1'b1, 1'b0, 64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, gap);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", er); end
        xact(0, 1'b0, 1'b1, BASE, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'h0000_0000_AB00_0000) begin errors++; $display("FAIL oor_wr_unchanged: got %h want 00000000ab000000", rd); end
        xact(0, 1'b1, 1'b1, BASE + 64'h10, 64'h0, 8'hFF, rd, er, gap);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL both_err: got %b want 1", er); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL both_rdata: got %h want 0", rd); end
        xact(0, 1'b0, 1'b1, BASE + 64'h10, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL both_unchanged: got %h want 1122334455667788", rd); end
        xact(0, 1'b0, 1'b0, BASE + 64'h10, 64'h0, 8'h00, rd, er, gap);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL noop_err: got %b want 0", er); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL noop_rdata: got %h want 0", rd); end
        xact(0, 1'b1, 1'b0, 64'h8000_7FF8, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, rd, er, gap);
        xact(0, 1'b0, 1'b1, 64'h8000_7FF8, 64'h0, 8'h00, rd, er, gap);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_err: got %b want 0", er); end
        checks++; if (rd !== 64'hDEAD_BEEF_0BAD_F00D) begin errors++; $display("FAIL last_rdata: got %h want deadbeef0badf00d", rd); end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd; logic er; int gap;
        @(negedge clk);
        rsp_ready = 1'b0;
        xact(0, 1'b0, 1'b1, BASE + 64'h10, 64'h0, 8'h00, rd, er, gap);
        checks++; if (gap !== 2) begin errors++; $display("FAIL bp_gap: got %0d want 2", gap); end
        // Requester tries to sneak in a write while the response is stalled.
        req_wen = 1'b1; req_ren = 1'b0; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", i, rsp_valid[0]); end
            checks++; if (rsp_rdata[0] !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL bp_rdata c%0d: got %h want 1122334455667788", i, rsp_rdata[0]); end
            checks++; if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL bp_err c%0d: got %b want 0", i, rsp_err[0]); end
            checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b want 0", i, req_ready[0]); end
        end
        req_valid[0] = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", req_ready[0]); end
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", rsp_valid[0]); end
        xact(0, 1'b0, 1'b1, BASE + 64'h10, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL bp_ignored_wr: got %h want 1122334455667788", rd); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int gap; int n;
        xact(0, 1'b1, 1'b0, BASE + 64'h20, 64'hA5A5_0000_1234_5678, 8'hFF, rd, er, gap);
        xact(0, 1'b0, 1'b1, BASE + 64'h20, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'hA5A5_0000_1234_5678) begin errors++; $display("FAIL pre_rst_rdata: got %h want a5a5000012345678", rd); end
        req_wen = 1'b1; req_ren = 1'b0; req_addr = BASE + 64'h20; req_wdata = 64'h0; req_wmask = 8'hFF;
        req_valid[0] = 1'b1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b want 0", rsp_valid[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready[0] !== 1'b1)  begin errors++; $display("FAIL mid_rst_ready: got %b want 1", req_ready[0]); end
        checks++; if (rsp_valid[0] !== 1'b0)  begin errors++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid[0]); end
        checks++; if (rsp_rdata[0] !== 64'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", rsp_rdata[0]); end
        checks++; if (rsp_err[0] !== 1'b0)    begin errors++; $display("FAIL mid_rst_err: got %b want 0", rsp_err[0]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(0, 1'b0, 1'b1, BASE + 64'h20, 64'h0, 8'h00, rd, er, gap);
        checks++; if (rd !== 64'hA5A5_0000_1234_5678) begin errors++; $display("FAIL aborted_wr: got %h want a5a5000012345678", rd); end
    endtask

    // Back-to-back random traffic against a small word model.
    task automatic test_sweep(input int k, input int lat);
        logic [63:0] model [8];
        logic [63:0] rd, wd, addr, exp_rd;
        logic        er, exp_er;
        logic [7:0]  m;
        int          gap, op, w;
        for (int i = 0; i < 8; i++) begin
            model[i] = {$urandom, $urandom};
            xact(k, 1'b1, 1'b0, BASE + 64'h200 + 64'(8 * i), model[i], 8'hFF, rd, er, gap);
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw%0d_preload_err w%0d: got %b want 0", lat, i, er); end
        end
        for (int t = 0; t < 20; t++) begin
            op = int'($urandom_range(0, 3));
            w  = int'($urandom_range(0, 7));
            addr = BASE + 64'h200 + 64'(8 * w) + 64'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            m  = 8'($urandom);
            exp_rd = 64'h0;
            exp_er = 1'b0;
            case (op)
                0, 1: begin
                    xact(k, 1'b0, 1'b1, addr, wd, m, rd, er, gap);
                    exp_rd = model[w];
                end
                2: begin
                    xact(k, 1'b1, 1'b0, addr, wd, m, rd, er, gap);
                    for (int b = 0; b < 8; b++) if (m[b]) model[w][8*b +: 8] = wd[8*b +: 8];
                end
                default: begin
                    xact(k, 1'b0, 1'b1, BASE - 64'(8 * (w + 1)), wd, m, rd, er, gap);
                    exp_er = 1'b1;
                end
            endcase
            checks++; if (rd !== exp_rd)  begin errors++; $display("FAIL sw%0d_rdata t%0d op%0d: got %h want %h", lat, t, op, rd, exp_rd); end
            checks++; if (er !== exp_er)  begin errors++; $display("FAIL sw%0d_err t%0d op%0d: got %b want %b", lat, t, op, er, exp_er); end
            checks++; if (gap !== lat)    begin errors++; $display("FAIL sw%0d_gap t%0d: got %0d want %0d", lat, t, gap, lat); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 3'b000;
        rsp_ready = 1'b1;
        req_wen = 1'b0; req_ren = 1'b0; req_addr = 64'h0; req_wdata = 64'h0; req_wmask = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_write_read();
        test_byte_write();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_sweep(1, 1);
        test_sweep(2, 15);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
